// File: rtl/shift_register_univ_pkg.sv
// Shared mode encodings and width helper for the universal shift register.
package shift_register_univ_pkg;

  typedef enum logic [2:0] {
    MODE_HOLD  = 3'b000,
    MODE_LOAD  = 3'b001,
    MODE_SHL   = 3'b010,
    MODE_SHR   = 3'b011,
    MODE_ROL   = 3'b100,
    MODE_ROR   = 3'b101,
    MODE_CLEAR = 3'b110,
    MODE_RSVD  = 3'b111
  } mode_e;

  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/dff_rst_cell.sv
// One-bit D flip-flop with asynchronous active-low reset to 0.
// Latency: 1 cycle, no backpressure.
module dff_rst_cell (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) q <= 1'b0;
    else        q <= d;
  end

endmodule

// File: rtl/shift_register_univ.sv
// Universal shift register: hold/load/shift/rotate/clear with a count of un-shifted loaded bits.
// Latency: 1 cycle from mode/d/ser_in to q and cnt; no backpressure (mode applied every edge).
module shift_register_univ
  import shift_register_univ_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [2:0]                    mode,
  input  logic [WIDTH-1:0]              d,
  input  logic                          ser_in_l,
  input  logic                          ser_in_r,
  output logic [WIDTH-1:0]              q,
  output logic                          ser_out_l,
  output logic                          ser_out_r,
  output logic [cnt_width(WIDTH)-1:0]   cnt,
  output logic                          drained
);

  localparam int CW = cnt_width(WIDTH);

  logic [WIDTH-1:0] q_nxt;

  // Unknown or reserved mode values fall through to the default and hold.
  always_comb begin
    q_nxt = q;
    case (mode)
      MODE_LOAD:  q_nxt = d;
      MODE_SHL:   q_nxt = {q[WIDTH-2:0], ser_in_r};
      MODE_SHR:   q_nxt = {ser_in_l, q[WIDTH-1:1]};
      MODE_ROL:   q_nxt = {q[WIDTH-2:0], q[WIDTH-1]};
      MODE_ROR:   q_nxt = {q[0], q[WIDTH-1:1]};
      MODE_CLEAR: q_nxt = '0;
      default:    q_nxt = q;
    endcase
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    dff_rst_cell u_cell (
      .clk   (clk),
      .rst_n (rst_n),
      .d     (q_nxt[i]),
      .q     (q[i])
    );
  end

  // cnt is bookkeeping only; shifting continues after it saturates at 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else begin
      case (mode)
        MODE_LOAD:          cnt <= CW'(WIDTH);
        MODE_SHL, MODE_SHR: if (cnt != '0) cnt <= cnt - CW'(1);
        MODE_CLEAR:         cnt <= '0;
        default:            cnt <= cnt;
      endcase
    end
  end

  assign ser_out_l = q[WIDTH-1];
  assign ser_out_r = q[0];
  assign drained   = (cnt == '0);

endmodule

// File: tb/tb_shift_register_univ.sv
// Scoreboard bench for shift_register_univ at WIDTH 8, plus 2 and 32 for the width sweep.
module tb_shift_register_univ;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [2:0] mode = 3'b000;
  logic [7:0] d = '0;
  logic       ser_in_l = 1'b0, ser_in_r = 1'b0;
  logic [7:0] q;
  logic       ser_out_l, ser_out_r, drained;
  logic [3:0] cnt;

  logic [2:0]  mode2 = 3'b000, mode32 = 3'b000;
  logic [1:0]  d2 = '0, q2;
  logic [31:0] d32 = '0, q32;
  logic [1:0]  cnt2;
  logic [5:0]  cnt32;
  logic        sol2, sor2, drained2, sol32, sor32, drained32;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [7:0] q;
    logic [3:0] cnt;
    logic       drained;
  } exp_t;

  exp_t sb[$];
  logic [7:0] mq = '0;
  int         mc = 0;

  always #5 clk = ~clk;

  shift_register_univ #(.WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .mode(mode), .d(d), .ser_in_l(ser_in_l), .ser_in_r(ser_in_r),
    .q(q), .ser_out_l(ser_out_l), .ser_out_r(ser_out_r), .cnt(cnt), .drained(drained)
  );

  shift_register_univ #(.WIDTH(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .mode(mode2), .d(d2), .ser_in_l(1'b0), .ser_in_r(1'b0),
    .q(q2), .ser_out_l(sol2), .ser_out_r(sor2), .cnt(cnt2), .drained(drained2)
  );

  shift_register_univ #(.WIDTH(32)) dut32 (
    .clk(clk), .rst_n(rst_n), .mode(mode32), .d(d32), .ser_in_l(1'b0), .ser_in_r(1'b0),
    .q(q32), .ser_out_l(sol32), .ser_out_r(sor32), .cnt(cnt32), .drained(drained32)
  );

  // Drive one cycle of stimulus on the 8-bit DUT and queue the expected state.
  task automatic drive(input logic [2:0] m, input logic [7:0] dv, input logic sl, input logic sr);
    exp_t e;
    mode = m; d = dv; ser_in_l = sl; ser_in_r = sr;
    case (m)
      3'b001: begin mq = dv; mc = 8; end
      3'b010: begin mq = {mq[6:0], sr}; if (mc > 0) mc--; end
      3'b011: begin mq = {sl, mq[7:1]}; if (mc > 0) mc--; end
      3'b100: mq = {mq[6:0], mq[7]};
      3'b101: mq = {mq[0], mq[7:1]};
      3'b110: begin mq = '0; mc = 0; end
      default: ;
    endcase
    e.q = mq; e.cnt = 4'(mc); e.drained = (mc == 0);
    sb.push_back(e);
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    exp_t e;
    #2;
    checks++;
    if (q !== 8'h00 || cnt !== 4'd0 || drained !== 1'b1 || ser_out_l !== 1'b0 || ser_out_r !== 1'b0) begin
      errors++; $display("FAIL reset_init: q=%h cnt=%0d drained=%b sol=%b sor=%b, want 00/0/1/0/0", q, cnt, drained, ser_out_l, ser_out_r);
    end
    checks++;
    if (q2 !== 2'b00 || cnt2 !== 2'd0 || drained2 !== 1'b1 || q32 !== 32'h0 || cnt32 !== 6'd0 || drained32 !== 1'b1) begin
      errors++; $display("FAIL reset_init_sweep: q2=%b cnt2=%0d q32=%h cnt32=%0d", q2, cnt2, q32, cnt32);
    end
    #10 rst_n = 1'b1;
    @(posedge clk); #1;
    drive(3'b001, 8'hA5, 1'b0, 1'b0);
    e = sb.pop_front();
    checks++;
    if (q !== e.q || cnt !== e.cnt) begin
      errors++; $display("FAIL reset_preload: q=%h cnt=%0d, want %h/%0d", q, cnt, e.q, e.cnt);
    end
    #2 rst_n = 1'b0;
    mq = '0; mc = 0;
    #1;
    checks++;
    if (q !== 8'h00 || cnt !== 4'd0 || drained !== 1'b1 || ser_out_l !== 1'b0 || ser_out_r !== 1'b0) begin
      errors++; $display("FAIL reset_async: q=%h cnt=%0d drained=%b sol=%b sor=%b, want 00/0/1/0/0", q, cnt, drained, ser_out_l, ser_out_r);
    end
    #2 rst_n = 1'b1;
  endtask

  task automatic test_load_shl();
    exp_t e;
    logic [7:0] pat;
    pat = 8'hB4;
    drive(3'b001, 8'hB4, 1'b0, 1'b0);
    e = sb.pop_front();
    checks++;
    if (q !== e.q || cnt !== e.cnt || drained !== e.drained) begin
      errors++; $display("FAIL load: q=%h cnt=%0d drained=%b, want %h/%0d/%b", q, cnt, drained, e.q, e.cnt, e.drained);
    end
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (ser_out_l !== pat[7-i]) begin
        errors++; $display("FAIL shl_serout[%0d]: got %b want %b", i, ser_out_l, pat[7-i]);
      end
      drive(3'b010, 8'h00, 1'b0, 1'b0);
      e = sb.pop_front();
      checks++;
      if (q !== e.q || cnt !== e.cnt || drained !== e.drained) begin
        errors++; $display("FAIL shl[%0d]: q=%h cnt=%0d drained=%b, want %h/%0d/%b", i, q, cnt, drained, e.q, e.cnt, e.drained);
      end
    end
    checks++;
    if (q !== 8'h00 || drained !== 1'b1) begin
      errors++; $display("FAIL shl_final: q=%h drained=%b, want 00/1", q, drained);
    end
  endtask

  task automatic test_shr_in();
    exp_t e;
    logic [7:0] bits;
    bits = 8'b0101_0011;  // bits[i] is the i-th serial bit applied
    drive(3'b110, 8'hFF, 1'b1, 1'b1);
    e = sb.pop_front();
    for (int i = 0; i < 8; i++) begin
      drive(3'b011, 8'hFF, bits[i], 1'b1);
      e = sb.pop_front();
      checks++;
      if (q !== e.q || cnt !== e.cnt) begin
        errors++; $display("FAIL shr[%0d]: q=%h cnt=%0d, want %h/%0d", i, q, cnt, e.q, e.cnt);
      end
    end
    checks++;
    if (q !== 8'h53 || cnt !== 4'd0 || drained !== 1'b1) begin
      errors++; $display("FAIL shr_final: q=%h cnt=%0d drained=%b, want 53/0/1", q, cnt, drained);
    end
  endtask

  task automatic test_rotate();
    exp_t e;
    drive(3'b001, 8'h81, 1'b0, 1'b0);
    e = sb.pop_front();
    drive(3'b100, 8'h00, 1'b1, 1'b1);
    e = sb.pop_front();
    checks++;
    if (q !== 8'h03 || cnt !== 4'd8 || q !== e.q) begin
      errors++; $display("FAIL rol: q=%h cnt=%0d, want 03/8", q, cnt);
    end
    for (int i = 0; i < 2; i++) begin
      drive(3'b101, 8'h00, 1'b1, 1'b1);
      e = sb.pop_front();
      checks++;
      if (q !== e.q || cnt !== e.cnt || ser_out_r !== e.q[0]) begin
        errors++; $display("FAIL ror[%0d]: q=%h cnt=%0d, want %h/%0d", i, q, cnt, e.q, e.cnt);
      end
    end
    checks++;
    if (q !== 8'hC0 || cnt !== 4'd8) begin
      errors++; $display("FAIL ror_final: q=%h cnt=%0d, want C0/8", q, cnt);
    end
  endtask

  task automatic test_overwrite_reserved();
    exp_t e;
    drive(3'b001, 8'hFF, 1'b0, 1'b0);
    e = sb.pop_front();
    for (int i = 0; i < 3; i++) begin
      drive(3'b011, 8'h00, 1'b0, 1'b0);
      e = sb.pop_front();
    end
    checks++;
    if (cnt !== 4'd5 || q !== 8'h1F || cnt !== e.cnt) begin
      errors++; $display("FAIL shr3: q=%h cnt=%0d, want 1F/5", q, cnt);
    end
    drive(3'b001, 8'h0F, 1'b0, 1'b0);
    e = sb.pop_front();
    checks++;
    if (q !== 8'h0F || cnt !== 4'd8) begin
      errors++; $display("FAIL overwrite: q=%h cnt=%0d, want 0F/8", q, cnt);
    end
    for (int i = 0; i < 4; i++) begin
      drive(3'b111, 8'hAA, 1'b1, 1'b1);
      e = sb.pop_front();
      checks++;
      if (q !== 8'h0F || cnt !== 4'd8 || q !== e.q) begin
        errors++; $display("FAIL reserved[%0d]: q=%h cnt=%0d, want 0F/8", i, q, cnt);
      end
    end
    drive(3'bxxx, 8'hAA, 1'b1, 1'b1);
    e = sb.pop_front();
    checks++;
    if (q !== 8'h0F || cnt !== 4'd8) begin
      errors++; $display("FAIL mode_x: q=%h cnt=%0d, want 0F/8", q, cnt);
    end
    mode = 3'b000;
  endtask

  task automatic test_width_sweep();
    logic [31:0] p32;
    p32 = 32'hDEADBEEF;
    mode2 = 3'b001; d2 = 2'b10;
    mode32 = 3'b001; d32 = p32;
    @(posedge clk); #1;
    checks++;
    if (cnt2 !== 2'd2 || q2 !== 2'b10 || cnt32 !== 6'd32 || q32 !== p32 || drained2 !== 1'b0 || drained32 !== 1'b0) begin
      errors++; $display("FAIL sweep_load: cnt2=%0d q2=%b cnt32=%0d q32=%h", cnt2, q2, cnt32, q32);
    end
    for (int i = 0; i < 32; i++) begin
      checks++;
      if (sol32 !== p32[31-i]) begin
        errors++; $display("FAIL sweep_serout32[%0d]: got %b want %b", i, sol32, p32[31-i]);
      end
      mode2 = (i < 2) ? 3'b010 : 3'b000;
      mode32 = 3'b010;
      @(posedge clk); #1;
      checks++;
      if (drained2 !== (i >= 1) || drained32 !== (i >= 31) ||
          cnt32 !== 6'(32 - i - 1) || cnt2 !== 2'((i >= 1) ? 0 : 1)) begin
        errors++; $display("FAIL sweep_shift[%0d]: cnt2=%0d drained2=%b cnt32=%0d drained32=%b", i, cnt2, drained2, cnt32, drained32);
      end
    end
    checks++;
    if (q2 !== 2'b00 || q32 !== 32'h0) begin
      errors++; $display("FAIL sweep_final: q2=%b q32=%h, want 0/0", q2, q32);
    end
    mode2 = 3'b000; mode32 = 3'b000;
  endtask

  initial begin
    test_reset();
    test_load_shl();
    test_shr_in();
    test_rotate();
    test_overwrite_reserved();
    test_width_sweep();
    checks++;
    if (sb.size() != 0) begin
      errors++; $display("FAIL scoreboard_leftover: %0d entries, want 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
